// File: rtl/maze_pkg.sv
// Shared definitions for the maze game: grid geometry, walker FSM states,
// move directions and the block-to-ROM address mapping.
package maze_pkg;

  localparam int unsigned GRID_COLS = 40;
  localparam int unsigned GRID_ROWS = 30;
  localparam int unsigned BLOCK_PX  = 16;

  typedef enum logic [1:0] {IDLE, READ, CHECK, WIN} walker_state_t;

  typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  // ROM holds one word per block, column-major with 32 rows per column.
  function automatic logic [10:0] block_addr(input logic [5:0] bcol, input logic [5:0] brow);
    return {bcol, 5'b0} + {5'b0, brow};
  endfunction

endpackage

// File: rtl/move_pacer.sv
// Auto-repeat pacer for held buttons.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   i_any_btn      at least one direction button held
//   i_frame_tick   one-cycle pulse per video frame
//   i_enable       walker is idle and may accept a move
//   i_clear        force the pace counter back to zero (game restart)
//   o_move_ok      strobe: start a move attempt this cycle
module move_pacer #(
  parameter int unsigned MOVE_FRAMES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_any_btn,
  input  logic i_frame_tick,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_move_ok
);

  logic [5:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d     = cnt_q;
    o_move_ok = 1'b0;
    if (i_clear || !i_any_btn) begin
      cnt_d = '0;
    end else if (i_frame_tick && i_enable) begin
      // Ticks while an attempt is in flight neither move nor count down.
      if (cnt_q == '0) begin
        o_move_ok = 1'b1;
        cnt_d     = 6'(MOVE_FRAMES - 1);
      end else begin
        cnt_d = cnt_q - 6'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/maze_walker.sv
// Player-movement controller: turns button presses into one-block moves,
// checks each target block against the maze ROM (port B) and flags a win
// when the player reaches the exit.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   i_up/i_down/i_left/i_right        debounced button levels
//   i_frame_tick                      one pulse per video frame
//   i_restart                         leave WIN and restart the game
//   o_rom_en/o_rom_addr/i_rom_data    ROM read port, data one cycle after enable
//   o_player_bcol/o_player_brow       player block position
//   o_exit_bcol/o_exit_brow           exit block position (constant)
//   o_win                             high while in WIN
//   o_moves                           successful move count
// Build option: define MAZE_MOVE_COUNTER_EN for a saturating move counter;
// otherwise o_moves is tied to zero.
module maze_walker
  import maze_pkg::*;
#(
  parameter int unsigned START_BCOL  = 1,
  parameter int unsigned START_BROW  = 1,
  parameter int unsigned EXIT_BCOL   = 38,
  parameter int unsigned EXIT_BROW   = 28,
  parameter int unsigned MOVE_FRAMES = 8,
  parameter logic [11:0] WALL_RGB    = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_up,
  input  logic        i_down,
  input  logic        i_left,
  input  logic        i_right,
  input  logic        i_frame_tick,
  input  logic        i_restart,
  output logic        o_rom_en,
  output logic [10:0] o_rom_addr,
  input  logic [15:0] i_rom_data,
  output logic [5:0]  o_player_bcol,
  output logic [5:0]  o_player_brow,
  output logic [5:0]  o_exit_bcol,
  output logic [5:0]  o_exit_brow,
  output logic        o_win,
  output logic [9:0]  o_moves
);

  localparam logic [5:0] StartCol = 6'(START_BCOL);
  localparam logic [5:0] StartRow = 6'(START_BROW);
  localparam logic [5:0] ExitCol  = 6'(EXIT_BCOL);
  localparam logic [5:0] ExitRow  = 6'(EXIT_BROW);
  localparam logic [5:0] LastCol  = 6'(GRID_COLS - 1);
  localparam logic [5:0] LastRow  = 6'(GRID_ROWS - 1);

  walker_state_t state_q, state_d;
  logic [5:0]    pcol_q, pcol_d, prow_q, prow_d;
  logic [5:0]    tcol_q, tcol_d, trow_q, trow_d;
  logic          rom_en_q, rom_en_d;
  logic          win_q, win_d;

  dir_t       dir;
  logic [5:0] cand_col, cand_row;
  logic       cand_ok;
  logic       any_btn, move_ok, pacer_en, restart_go, passable, at_exit;
  logic       unused_rom_bits;

  assign any_btn    = i_up | i_down | i_left | i_right;
  assign pacer_en   = (state_q == IDLE);
  assign restart_go = (state_q == WIN) && i_restart;
  assign passable   = (i_rom_data[15:4] != WALL_RGB);
  assign at_exit    = (tcol_q == ExitCol) && (trow_q == ExitRow);
  // Low nibble of the ROM word carries no wall information.
  assign unused_rom_bits = ^i_rom_data[3:0];

  move_pacer #(
    .MOVE_FRAMES(MOVE_FRAMES)
  ) u_pacer (
    .clk         (clk),
    .rst         (rst),
    .i_any_btn   (any_btn),
    .i_frame_tick(i_frame_tick),
    .i_enable    (pacer_en),
    .i_clear     (restart_go),
    .o_move_ok   (move_ok)
  );

  // Direction priority up > down > left > right, with grid bounds check.
  always_comb begin
    dir = DIR_NONE;
    if      (i_up)    dir = DIR_UP;
    else if (i_down)  dir = DIR_DOWN;
    else if (i_left)  dir = DIR_LEFT;
    else if (i_right) dir = DIR_RIGHT;

    cand_col = pcol_q;
    cand_row = prow_q;
    cand_ok  = 1'b0;
    case (dir)
      DIR_UP: begin
        cand_ok  = (prow_q != 6'd0);
        cand_row = prow_q - 6'd1;
      end
      DIR_DOWN: begin
        cand_ok  = (prow_q < LastRow);
        cand_row = prow_q + 6'd1;
      end
      DIR_LEFT: begin
        cand_ok  = (pcol_q != 6'd0);
        cand_col = pcol_q - 6'd1;
      end
      DIR_RIGHT: begin
        cand_ok  = (pcol_q < LastCol);
        cand_col = pcol_q + 6'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pcol_d   = pcol_q;
    prow_d   = prow_q;
    tcol_d   = tcol_q;
    trow_d   = trow_q;
    rom_en_d = 1'b0;
    win_d    = win_q;
    case (state_q)
      IDLE: begin
        if (move_ok && cand_ok) begin
          tcol_d   = cand_col;
          trow_d   = cand_row;
          rom_en_d = 1'b1;
          state_d  = READ;
        end
      end
      READ: state_d = CHECK;
      CHECK: begin
        state_d = IDLE;
        if (passable) begin
          pcol_d = tcol_q;
          prow_d = trow_q;
          if (at_exit) begin
            state_d = WIN;
            win_d   = 1'b1;
          end
        end
      end
      WIN: begin
        if (i_restart) begin
          pcol_d  = StartCol;
          prow_d  = StartRow;
          win_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pcol_q   <= StartCol;
      prow_q   <= StartRow;
      tcol_q   <= '0;
      trow_q   <= '0;
      rom_en_q <= 1'b0;
      win_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcol_q   <= pcol_d;
      prow_q   <= prow_d;
      tcol_q   <= tcol_d;
      trow_q   <= trow_d;
      rom_en_q <= rom_en_d;
      win_q    <= win_d;
    end
  end

`ifdef MAZE_MOVE_COUNTER_EN
  logic [9:0] moves_q, moves_d;

  always_comb begin
    moves_d = moves_q;
    if (restart_go) begin
      moves_d = '0;
    end else if ((state_q == CHECK) && passable && (moves_q != 10'h3FF)) begin
      moves_d = moves_q + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) moves_q <= '0;
    else     moves_q <= moves_d;
  end

  assign o_moves = moves_q;
`else
  assign o_moves = '0;
`endif

  assign o_rom_en      = rom_en_q;
  assign o_rom_addr    = block_addr(tcol_q, trow_q);
  assign o_player_bcol = pcol_q;
  assign o_player_brow = prow_q;
  assign o_exit_bcol   = ExitCol;
  assign o_exit_brow   = ExitRow;
  assign o_win         = win_q;

endmodule

// File: tb/tb_maze_walker.sv
// Self-checking bench for maze_walker: directed scenarios followed by
// randomized button/tick/restart traffic, checked against a block-level
// game model.
module tb_maze_walker;

  localparam int MF = 4;
  localparam int SC = 1;
  localparam int SR = 1;
  localparam int EC = 38;
  localparam int ER = 28;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_up = 1'b0, i_down = 1'b0, i_left = 1'b0, i_right = 1'b0;
  logic        i_frame_tick = 1'b0;
  logic        i_restart = 1'b0;
  logic        o_rom_en;
  logic [10:0] o_rom_addr;
  logic [15:0] i_rom_data = '0;
  logic [5:0]  o_player_bcol, o_player_brow, o_exit_bcol, o_exit_brow;
  logic        o_win;
  logic [9:0]  o_moves;

  always #5 clk = ~clk;

  maze_walker #(
    .START_BCOL (SC),
    .START_BROW (SR),
    .EXIT_BCOL  (EC),
    .EXIT_BROW  (ER),
    .MOVE_FRAMES(MF),
    .WALL_RGB   (12'h000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_up         (i_up),
    .i_down       (i_down),
    .i_left       (i_left),
    .i_right      (i_right),
    .i_frame_tick (i_frame_tick),
    .i_restart    (i_restart),
    .o_rom_en     (o_rom_en),
    .o_rom_addr   (o_rom_addr),
    .i_rom_data   (i_rom_data),
    .o_player_bcol(o_player_bcol),
    .o_player_brow(o_player_brow),
    .o_exit_bcol  (o_exit_bcol),
    .o_exit_brow  (o_exit_brow),
    .o_win        (o_win),
    .o_moves      (o_moves)
  );

  // Maze ROM, synchronous read.
  logic [15:0] mem [0:2047];
  always @(posedge clk) if (o_rom_en) i_rom_data <= mem[o_rom_addr];

  // Count ROM read cycles.
  int rd_count = 0;
  always @(negedge clk) if (o_rom_en) rd_count <= rd_count + 1;

  int n_checks = 0;
  int n_err    = 0;

  // Game model state.
  int m_col, m_row, m_moves, m_win, m_pace, m_reads, m_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit open_blk(input int c, input int r);
    logic [15:0] w;
    w = mem[c * 32 + r];
    return w[15:4] != 12'h000;
  endfunction

  task automatic model_reset();
    m_col = SC; m_row = SR; m_moves = 0; m_win = 0; m_pace = 0; m_addr = 0;
  endtask

  // btn = {up, down, left, right}
  task automatic model_attempt(input logic [3:0] btn);
    int tc, tr;
    tc = m_col; tr = m_row;
    if      (btn[3]) tr = tr - 1;
    else if (btn[2]) tr = tr + 1;
    else if (btn[1]) tc = tc - 1;
    else             tc = tc + 1;
    if (tc < 0 || tc > 39 || tr < 0 || tr > 29) return;
    m_reads++;
    m_addr = tc * 32 + tr;
    if (open_blk(tc, tr)) begin
      m_col = tc; m_row = tr;
      if (m_moves < 1023) m_moves++;
      if (tc == EC && tr == ER) m_win = 1;
    end
  endtask

  task automatic model_event(input logic [3:0] btn, input bit tick, input bit restart);
    if (btn == 4'b0) m_pace = 0;
    if (m_win != 0) begin
      if (restart) begin
        m_col = SC; m_row = SR; m_moves = 0; m_win = 0; m_pace = 0;
      end
    end else if (btn != 4'b0 && tick) begin
      if (m_pace == 0) begin
        m_pace = MF - 1;
        model_attempt(btn);
      end else begin
        m_pace--;
      end
    end
  endtask

  task automatic check_all(input string tag);
    int exp_moves;
`ifdef MAZE_MOVE_COUNTER_EN
    exp_moves = m_moves;
`else
    exp_moves = 0;
`endif
    chk({tag, ".col"},   32'(o_player_bcol), m_col);
    chk({tag, ".row"},   32'(o_player_brow), m_row);
    chk({tag, ".win"},   32'(o_win),         m_win);
    chk({tag, ".moves"}, 32'(o_moves),       exp_moves);
    chk({tag, ".reads"}, rd_count,           m_reads);
    chk({tag, ".addr"},  32'(o_rom_addr),    m_addr);
    chk({tag, ".en"},    32'(o_rom_en),      0);
  endtask

  task automatic step(input string tag, input logic [3:0] btn, input bit tick, input bit restart);
    @(negedge clk);
    {i_up, i_down, i_left, i_right} = btn;
    @(negedge clk);
    i_frame_tick = tick;
    i_restart    = restart;
    @(negedge clk);
    i_frame_tick = 1'b0;
    i_restart    = 1'b0;
    repeat (3) @(negedge clk);
    model_event(btn, tick, restart);
    check_all(tag);
  endtask

  task automatic go(input string tag, input logic [3:0] btn);
    step(tag, btn, 1'b1, 1'b0);
    step({tag, ".rel"}, 4'b0, 1'b0, 1'b0);
  endtask

  localparam logic [3:0] BU = 4'b1000, BD = 4'b0100, BL = 4'b0010, BR = 4'b0001;

  initial begin
    int r0;
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    for (int r = 0; r <= 10; r++) mem[1 * 32 + r] = 16'hFFF0;
    for (int r = 0; r <= 10; r++) mem[0 * 32 + r] = 16'h8A50;
    for (int c = 0; c <= 38; c++) mem[c * 32 + 10] = 16'h123F;
    for (int r = 10; r <= 28; r++) mem[38 * 32 + r] = 16'hFFF0;
    mem[2 * 32 + 3] = 16'hFFF0;   // makes right a live alternative for the priority test
    mem[2 * 32 + 1] = 16'h000F;   // wall with non-zero low nibble

    m_reads = 0;
    model_reset();

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst.exit_col", 32'(o_exit_bcol), EC);
    chk("rst.exit_row", 32'(o_exit_brow), ER);
    check_all("rst");
    rst = 1'b0;
    @(negedge clk);

    // Wall to the right of the start block.
    go("wall", BR);
    chk("wall.addr65", 32'(o_rom_addr), 65);

    // Free block below: cycle-accurate timing, plus a tick during READ that must be ignored.
    @(negedge clk); {i_up, i_down, i_left, i_right} = BD;
    @(negedge clk); i_frame_tick = 1'b1;
    @(negedge clk);
    chk("free.t1_en",   32'(o_rom_en),      1);
    chk("free.t1_addr", 32'(o_rom_addr),    34);
    chk("free.t1_row",  32'(o_player_brow), 1);
    @(negedge clk); i_frame_tick = 1'b0;
    chk("free.t2_en",   32'(o_rom_en),      0);
    chk("free.t2_row",  32'(o_player_brow), 1);
    @(negedge clk);
    chk("free.t3_row",  32'(o_player_brow), 2);
    model_event(BD, 1'b1, 1'b0);
    check_all("free");
    // Still held: next move only on the fourth further tick.
    for (int k = 0; k < 4; k++) step("hold", BD, 1'b1, 1'b0);
    chk("hold.row3", 32'(o_player_brow), 3);
    step("rel", 4'b0, 1'b0, 1'b0);

    // Up + right together: up wins.
    go("prio", BU | BR);
    chk("prio.col", 32'(o_player_bcol), 1);
    chk("prio.row", 32'(o_player_brow), 2);

    // Walk to the corner and push against both edges.
    go("nav", BL);
    go("nav", BU);
    go("nav", BU);
    r0 = rd_count;
    go("edge_up", BU);
    go("edge_left", BL);
    chk("edge.noread", rd_count, r0);
    chk("edge.col", 32'(o_player_bcol), 0);
    chk("edge.row", 32'(o_player_brow), 0);

    // Held button over nine ticks: moves on ticks 1, 5 and 9.
    for (int k = 0; k < 9; k++) step("pace", BD, 1'b1, 1'b0);
    chk("pace.row", 32'(o_player_brow), 3);
    step("pace.rel", 4'b0, 1'b0, 1'b0);

    // Route to the exit.
    for (int k = 0; k < 7; k++) go("down0", BD);
    step("rst_nowin", 4'b0, 1'b0, 1'b1);
    for (int k = 0; k < 38; k++) go("right10", BR);
    for (int k = 0; k < 17; k++) go("down38", BD);
    go("win", BD);
    chk("win.flag", 32'(o_win), 1);
    chk("win.row", 32'(o_player_brow), 28);
    go("win.ignore", BU);
    chk("win.still_row", 32'(o_player_brow), 28);
    step("restart", 4'b0, 1'b0, 1'b1);
    chk("restart.win", 32'(o_win), 0);
    chk("restart.col", 32'(o_player_bcol), SC);
    chk("restart.row", 32'(o_player_brow), SR);

    // Reset during READ aborts the attempt at once.
    @(negedge clk); {i_up, i_down, i_left, i_right} = BD;
    @(negedge clk); i_frame_tick = 1'b1;
    @(negedge clk); i_frame_tick = 1'b0;
    chk("midrst.en_before", 32'(o_rom_en), 1);
    #2 rst = 1'b1;
    #1 chk("midrst.en_now", 32'(o_rom_en), 0);
    m_reads++;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step("midrst.after", 4'b0, 1'b0, 1'b0);
    go("midrst.move", BD);
    chk("midrst.row", 32'(o_player_brow), 2);

    // Random maze and random traffic.
    for (int i = 0; i < 2048; i++) begin
      if ($urandom_range(0, 3) == 0) mem[i] = {12'h000, 4'($urandom)};
      else                           mem[i] = {12'($urandom_range(1, 4095)), 4'($urandom)};
    end
    for (int k = 0; k < 200; k++) begin
      step("rand", 4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/maze_walker.md
# maze_walker

Player-movement controller for the maze game. It converts button presses into one-block moves and checks each target block against the maze ROM through the ROM's second read port (`rom_en`/`rom_addr`/`rom_data`). It drives the player and exit block coordinates consumed by the frame renderer and flags a win when the player reaches the exit.

## Interface
- `START_BCOL`, default 1: player start column, in blocks.
- `START_BROW`, default 1: player start row, in blocks.
- `EXIT_BCOL`, default 38: exit column, in blocks.
- `EXIT_BROW`, default 28: exit row, in blocks.
- `MOVE_FRAMES`, default 8: frame ticks between auto-repeat moves while a button is held (range 1..63).
- `WALL_RGB`, default 12'h000: ROM colour `[15:4]` that marks a wall block.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `i_up`, `i_down`, `i_left`, `i_right` in 1 each: debounced button levels.
- `i_frame_tick` in 1: one-cycle pulse per video frame.
- `i_restart` in 1: one-cycle pulse; restarts the game from the win state.
- `o_rom_en` out 1: ROM port-B read enable.
- `o_rom_addr` out 11: ROM port-B address.
- `i_rom_data` in 16: ROM port-B data, valid the cycle after `o_rom_en`.
- `o_player_bcol`, `o_player_brow` out 6 each: player block position.
- `o_exit_bcol`, `o_exit_brow` out 6 each: exit block position, constant from the parameters.
- `o_win` out 1: high while in WIN.
- `o_moves` out 10: count of successful moves.

## Operation
- Grid is 40 columns × 30 rows of 16×16 px blocks. Legal positions: bcol 0..39, brow 0..29.
- ROM address = bcol*32 + brow (equivalently `{bcol[5:0], brow[4:0]}`).
- A block is passable iff `i_rom_data[15:4] != WALL_RGB`.
- Direction select, fixed priority up > down > left > right:
  - up: brow-1
  - down: brow+1
  - left: bcol-1
  - right: bcol+1
- Pace counter (6 bit):
  - Cleared to 0 whenever no button is held.
  - On `i_frame_tick` with counter ≠ 0, it decrements.
  - A move attempt may start only on `i_frame_tick` with counter == 0 and at least one button held. That attempt loads the counter with MOVE_FRAMES-1.
- FSM states and transitions:
  - **IDLE**: on an eligible tick, compute the target.
    - Target out of range (brow-1 from 0, bcol+1 from 39, etc.): stay in IDLE, no ROM read. The pace counter still reloads.
    - Otherwise latch the target and go to READ.
  - **READ**: `o_rom_en`=1, `o_rom_addr`=target address. Go to CHECK.
  - **CHECK**: sample `i_rom_data`.
    - Passable: player position ← target and the move counter increments. Go to WIN if the target equals the exit, else IDLE.
    - Wall: position unchanged; go to IDLE.
  - **WIN**: `o_win`=1; buttons and ticks are ignored. On `i_restart`, position returns to start, `o_moves` clears to 0, the pace counter clears, and the FSM goes to IDLE.
- `i_restart` outside WIN has no effect.
- `o_rom_en` is 0 in every state except READ. `o_rom_addr` holds the latched target in all states.
- A tick arriving during READ or CHECK is ignored. The pace counter does not decrement on it.
- A button change during READ or CHECK does not alter the latched target.

## Timing
- Eligible tick sampled in IDLE at cycle T. `o_rom_en` is high at T+1. Data is checked at T+2. The new position and `o_win` are visible at T+3.
- One move attempt at most per frame tick. Held-button repeat rate is one attempt per MOVE_FRAMES ticks.
- Reset values:
  - `o_player_bcol`/`o_player_brow` = START_BCOL/START_BROW
  - `o_exit_*` = EXIT parameters
  - `o_rom_en` = 0, `o_rom_addr` = 0
  - `o_win` = 0, `o_moves` = 0
  - FSM in IDLE, pace counter 0
- Reset asserted mid-attempt aborts it immediately. No position update occurs.

## Configuration
- `MAZE_MOVE_COUNTER_EN` defined:
  - `o_moves` counts successful moves and saturates at 1023.
  - Cleared on reset and on restart.
- `MAZE_MOVE_COUNTER_EN` undefined: `o_moves` is tied to 0 and no counter register exists.

## Structure
- Shared package `maze_pkg`:
  - constants GRID_COLS=40, GRID_ROWS=30, BLOCK_PX=16
  - `walker_state_t` enum {IDLE, READ, CHECK, WIN}
  - `dir_t` enum {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT}
  - function `block_addr(bcol, brow)`
- One sub-module, `move_pacer`: holds the pace counter and outputs a `move_ok` strobe. The FSM, target calculation and bounds checking stay in `maze_walker`.

## Test plan
- Free target: start (1,1), ROM (1,2) = 16'hFFF0, `i_down` held, one tick at T → `o_rom_en`=1 with addr 34 at T+1; position (1,2) at T+3; `o_moves`=1.
- Wall target: ROM (2,1) = 16'h0000, `i_right`, one tick → addr 65 read; position stays (1,1); `o_moves`=0.
- Edge: player at (0,5), `i_left`, tick → no `o_rom_en` pulse, position unchanged. Simultaneous `i_up`+`i_right` → up is taken.
- Repeat pacing: MOVE_FRAMES=4, open corridor, `i_down` held over 9 ticks → exactly 3 moves, on ticks 1, 5 and 9.
- Win/restart: player at (38,27), ROM (38,28) free, `i_down`, tick → position (38,28), `o_win`=1; further presses ignored. `i_restart` → (1,1), `o_win`=0, `o_moves`=0.
- Reset mid-op: assert `rst` in the READ cycle → `o_rom_en`=0 immediately; after release, position (1,1), FSM in IDLE.
